// File: rtl/ysyx_22050550_axi_arbiter_if.sv
// AXI-style bus bundle: AR/R read and AW/W write channels of one port.
// Ports: master modport drives requests and w data; slave modport answers.
interface ysyx_22050550_axi_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
);
   localparam int STRB_W = DATA_W / 8;

   logic              ar_valid;
   logic              ar_ready;
   logic [ADDR_W-1:0] ar_addr;
   logic [LEN_W-1:0]  ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;
   logic              r_ready;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic              r_last;
   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] aw_addr;
   logic [LEN_W-1:0]  aw_len;
   logic [2:0]        aw_size;
   logic [1:0]        aw_burst;
   logic              w_valid;
   logic [DATA_W-1:0] w_data;
   logic [STRB_W-1:0] w_strb;
   logic              w_ready;

   modport master (
      output ar_valid, ar_addr, ar_len,
      output ar_size, ar_burst, r_ready,
      output aw_valid, aw_addr, aw_len,
      output aw_size, aw_burst,
      output w_valid, w_data, w_strb,
      input  ar_ready, r_valid, r_data,
      input  r_last, aw_ready, w_ready
   );

   modport slave (
      input  ar_valid, ar_addr, ar_len,
      input  ar_size, ar_burst, r_ready,
      input  aw_valid, aw_addr, aw_len,
      input  aw_size, aw_burst,
      input  w_valid, w_data, w_strb,
      output ar_ready, r_valid, r_data,
      output r_last, aw_ready, w_ready
   );
endinterface

// File: rtl/ysyx_22050550_axi_arbiter.sv
// 2:1 arbiter: m0 (ICache) and m1 (DCache) onto one SRAM slave port.
// Ports: clock, reset (async, active-low), m0/m1 slave modports, s master
// modport. Read and write channels hold a grant for a whole burst.
// Macro YSYX_22050550_ARB_FIXED_PRIO_EN: m1 always wins ties, no
// last-grant state; otherwise round-robin per channel.
module ysyx_22050550_axi_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int LEN_W  = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   ysyx_22050550_axi_arbiter_if.slave    m0,
   ysyx_22050550_axi_arbiter_if.slave    m1,
   ysyx_22050550_axi_arbiter_if.master   s
);
   typedef enum logic [2:0] {
      R_IDLE, R_ADDR0, R_ADDR1, R_DATA0, R_DATA1
   } r_state_t;

   typedef enum logic [2:0] {
      W_IDLE, W_ADDR0, W_ADDR1, W_DATA0, W_DATA1
   } w_state_t;

   r_state_t         r_st, r_nxt;
   w_state_t         w_st, w_nxt;
   logic [LEN_W-1:0] w_cnt;
   logic             w_load, w_dec;
   logic             r_pick1, w_pick1;

`ifdef YSYX_22050550_ARB_FIXED_PRIO_EN
   assign r_pick1 = m1.ar_valid;
   assign w_pick1 = m1.aw_valid;
`else
   // set = m1 held the previous grant on that channel
   logic r_last1, w_last1;

   assign r_pick1 = m1.ar_valid & (~m0.ar_valid | ~r_last1);
   assign w_pick1 = m1.aw_valid & (~m0.aw_valid | ~w_last1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_last1 <= 1'b1;
         w_last1 <= 1'b1;
      end else begin
         if (r_st == R_IDLE && (m0.ar_valid | m1.ar_valid))
            r_last1 <= r_pick1;
         if (w_st == W_IDLE && (m0.aw_valid | m1.aw_valid))
            w_last1 <= w_pick1;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_st  <= R_IDLE;
         w_st  <= W_IDLE;
         w_cnt <= '0;
      end else begin
         r_st <= r_nxt;
         w_st <= w_nxt;
         if (w_load)
            w_cnt <= s.aw_len;
         else if (w_dec)
            w_cnt <= w_cnt - LEN_W'(1);
      end
   end

   always_comb begin
      r_nxt       = r_st;
      s.ar_valid  = 1'b0;
      s.ar_addr   = {ADDR_W{1'b0}};
      s.ar_len    = '0;
      s.ar_size   = 3'd0;
      s.ar_burst  = 2'd0;
      s.r_ready   = 1'b0;
      m0.ar_ready = 1'b0;
      m0.r_valid  = 1'b0;
      m0.r_data   = {DATA_W{1'b0}};
      m0.r_last   = 1'b0;
      m1.ar_ready = 1'b0;
      m1.r_valid  = 1'b0;
      m1.r_data   = {DATA_W{1'b0}};
      m1.r_last   = 1'b0;
      unique case (r_st)
         R_IDLE: begin
            if (m0.ar_valid | m1.ar_valid)
               r_nxt = r_pick1 ? R_ADDR1 : R_ADDR0;
         end
         R_ADDR0: begin
            s.ar_valid  = m0.ar_valid;
            s.ar_addr   = m0.ar_addr;
            s.ar_len    = m0.ar_len;
            s.ar_size   = m0.ar_size;
            s.ar_burst  = m0.ar_burst;
            m0.ar_ready = s.ar_ready;
            if (m0.ar_valid & s.ar_ready)
               r_nxt = R_DATA0;
         end
         R_ADDR1: begin
            s.ar_valid  = m1.ar_valid;
            s.ar_addr   = m1.ar_addr;
            s.ar_len    = m1.ar_len;
            s.ar_size   = m1.ar_size;
            s.ar_burst  = m1.ar_burst;
            m1.ar_ready = s.ar_ready;
            if (m1.ar_valid & s.ar_ready)
               r_nxt = R_DATA1;
         end
         R_DATA0: begin
            s.r_ready  = m0.r_ready;
            m0.r_valid = s.r_valid;
            m0.r_data  = s.r_data;
            m0.r_last  = s.r_last;
            if (s.r_valid & m0.r_ready & s.r_last)
               r_nxt = R_IDLE;
         end
         R_DATA1: begin
            s.r_ready  = m1.r_ready;
            m1.r_valid = s.r_valid;
            m1.r_data  = s.r_data;
            m1.r_last  = s.r_last;
            if (s.r_valid & m1.r_ready & s.r_last)
               r_nxt = R_IDLE;
         end
         default: r_nxt = R_IDLE;
      endcase
   end

   // The slave has no w_last: w_cnt counts beats left after this one.
   always_comb begin
      w_nxt       = w_st;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      s.aw_valid  = 1'b0;
      s.aw_addr   = {ADDR_W{1'b0}};
      s.aw_len    = '0;
      s.aw_size   = 3'd0;
      s.aw_burst  = 2'd0;
      s.w_valid   = 1'b0;
      s.w_data    = {DATA_W{1'b0}};
      s.w_strb    = '0;
      m0.aw_ready = 1'b0;
      m0.w_ready  = 1'b0;
      m1.aw_ready = 1'b0;
      m1.w_ready  = 1'b0;
      unique case (w_st)
         W_IDLE: begin
            if (m0.aw_valid | m1.aw_valid)
               w_nxt = w_pick1 ? W_ADDR1 : W_ADDR0;
         end
         W_ADDR0: begin
            s.aw_valid  = m0.aw_valid;
            s.aw_addr   = m0.aw_addr;
            s.aw_len    = m0.aw_len;
            s.aw_size   = m0.aw_size;
            s.aw_burst  = m0.aw_burst;
            m0.aw_ready = s.aw_ready;
            if (m0.aw_valid & s.aw_ready) begin
               w_load = 1'b1;
               w_nxt  = W_DATA0;
            end
         end
         W_ADDR1: begin
            s.aw_valid  = m1.aw_valid;
            s.aw_addr   = m1.aw_addr;
            s.aw_len    = m1.aw_len;
            s.aw_size   = m1.aw_size;
            s.aw_burst  = m1.aw_burst;
            m1.aw_ready = s.aw_ready;
            if (m1.aw_valid & s.aw_ready) begin
               w_load = 1'b1;
               w_nxt  = W_DATA1;
            end
         end
         W_DATA0: begin
            s.w_valid  = m0.w_valid;
            s.w_data   = m0.w_data;
            s.w_strb   = m0.w_strb;
            m0.w_ready = s.w_ready;
            if (m0.w_valid & s.w_ready) begin
               if (w_cnt == '0) w_nxt = W_IDLE;
               else             w_dec = 1'b1;
            end
         end
         W_DATA1: begin
            s.w_valid  = m1.w_valid;
            s.w_data   = m1.w_data;
            s.w_strb   = m1.w_strb;
            m1.w_ready = s.w_ready;
            if (m1.w_valid & s.w_ready) begin
               if (w_cnt == '0) w_nxt = W_IDLE;
               else             w_dec = 1'b1;
            end
         end
         default: w_nxt = W_IDLE;
      endcase
   end
endmodule
